set_time_module: RTL and testbench

- Downstream consumer of the control state machine's `set_time_en`.
- While `set_time_en` is high, the block takes a snapshot of the running time and lets the user edit hours, minutes and seconds with debounced key pulses.
- On exit it issues a one-cycle `load_time` pulse carrying the edited time to the timekeeping counters.
- It also drives the field-select and blink signals for the display.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/wrap_updown_counter.sv | 40 ++++
 rtl/set_time_module.sv | 162 ++++++++++++++++
 tb/tb_set_time_module.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time/date/alarm setting blocks.
//   field_e      : display field selector (none/hour/min/sec)
//   edit_state_e : state encoding of the set-time edit controller
//   HOUR_W, MINSEC_W, HOUR_MAX, MINSEC_MAX : field widths and wrap limits
package clock_pkg;

    localparam int HOUR_W     = 5;
    localparam int MINSEC_W   = 6;
    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_SEC  = 3'd3,
        ST_COMMIT    = 3'd4
    } edit_state_e;

endpackage

// File: rtl/wrap_updown_counter.sv
// Modulo up/down counter with parallel load.
//   clk, rst_n : clock, synchronous active-low reset (clears value)
//   load       : load load_val (takes priority over counting)
//   inc, dec   : single-cycle step requests; both together cancel
//   en         : gates inc/dec
//   value      : current count, kept within 0..MAX by wrapping
module wrap_updown_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (inc != dec)) begin
            // A loaded value beyond MAX is not meaningful; any step restarts at 0.
            if (value > MAX_V) begin
                value <= '0;
            end else if (inc) begin
                value <= (value == MAX_V) ? '0 : value + 1'b1;
            end else begin
                value <= (value == '0) ? MAX_V : value - 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_time_module.sv
// Time-setting controller. While set_time_en is high it snapshots the running
// time and lets the user edit hour/min/sec with key pulses; on exit it emits a
// one-cycle load_time strobe carrying the edited time. Also drives the
// display field select and blink control.
//   clk, rst_n              : clock, synchronous active-low reset
//   set_time_en             : level, edit mode requested
//   shift_key/inc_key/dec_key : debounced single-cycle key pulses
//   cur_hour/cur_min/cur_sec  : running time, captured on edit entry
//   set_hour/set_min/set_sec  : edited time
//   load_time               : commit strobe, set_* valid in that cycle
//   sel_field               : 0 none, 1 hour, 2 min, 3 sec
//   blink                   : display blank control for the selected field
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | not editing; set_* hold; enters edit with fresh capture
// ST_EDIT_HOUR | editing hour; shift -> min; enable low -> commit
// ST_EDIT_MIN  | editing minute; shift -> sec; enable low -> commit
// ST_EDIT_SEC  | editing second; shift -> hour; enable low -> commit
// ST_COMMIT    | one-cycle load_time strobe, then back to idle
module set_time_module #(
    parameter int BLINK_DIV  = 25_000_000,
    parameter int HOUR_MAX   = clock_pkg::HOUR_MAX,
    parameter int MINSEC_MAX = clock_pkg::MINSEC_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_time_en,
    input  logic       shift_key,
    input  logic       inc_key,
    input  logic       dec_key,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load_time,
    output logic [1:0] sel_field,
    output logic       blink
);

    import clock_pkg::*;

    localparam int                CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_DIV - 1);

    edit_state_e      state;
    edit_state_e      state_nx;
    field_e           field;
    logic             capture;
    logic             commit;
    logic             keys_live;
    logic             key_any;
    logic [CNT_W-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        commit   = 1'b0;
        field    = FIELD_NONE;
        unique case (state)
            ST_IDLE: begin
                if (set_time_en) begin
                    capture  = 1'b1;
                    state_nx = ST_EDIT_HOUR;
                end
            end
            ST_EDIT_HOUR: begin
                field = FIELD_HOUR;
                if (!set_time_en)   state_nx = ST_COMMIT;
                else if (shift_key) state_nx = ST_EDIT_MIN;
            end
            ST_EDIT_MIN: begin
                field = FIELD_MIN;
                if (!set_time_en)   state_nx = ST_COMMIT;
                else if (shift_key) state_nx = ST_EDIT_SEC;
            end
            ST_EDIT_SEC: begin
                field = FIELD_SEC;
                if (!set_time_en)   state_nx = ST_COMMIT;
                else if (shift_key) state_nx = ST_EDIT_HOUR;
            end
            ST_COMMIT: begin
                commit   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Exit from edit outranks keys: a key in the same cycle as enable-low is dropped.
    assign keys_live = (field != FIELD_NONE) && set_time_en;
    assign key_any   = keys_live && (shift_key || inc_key || dec_key);

    wrap_updown_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .load_val (cur_hour),
        .inc      (inc_key),
        .dec      (dec_key),
        .en       (keys_live && (field == FIELD_HOUR)),
        .value    (set_hour)
    );

    wrap_updown_counter #(.WIDTH(MINSEC_W), .MAX(MINSEC_MAX)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .load_val (cur_min),
        .inc      (inc_key),
        .dec      (dec_key),
        .en       (keys_live && (field == FIELD_MIN)),
        .value    (set_min)
    );

    wrap_updown_counter #(.WIDTH(MINSEC_W), .MAX(MINSEC_MAX)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .load_val (cur_sec),
        .inc      (inc_key),
        .dec      (dec_key),
        .en       (keys_live && (field == FIELD_SEC)),
        .value    (set_sec)
    );

    // Entry and every key restart the blink period with the field shown, so the
    // user sees the effect of the key immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (capture || key_any) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (keys_live) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end
    end

    assign load_time = commit;
    assign sel_field = field;

endmodule

// File: tb/tb_set_time_module.sv
// Directed self-checking bench for set_time_module (BLINK_DIV = 4).
module tb_set_time_module;

    logic       clk;
    logic       rst_n;
    logic       set_time_en;
    logic       shift_key;
    logic       inc_key;
    logic       dec_key;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load_time;
    logic [1:0] sel_field;
    logic       blink;

    int n_vec = 0;
    int n_mis = 0;

    set_time_module #(.BLINK_DIV(4), .HOUR_MAX(23), .MINSEC_MAX(59)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_time_en (set_time_en),
        .shift_key   (shift_key),
        .inc_key     (inc_key),
        .dec_key     (dec_key),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .load_time   (load_time),
        .sel_field   (sel_field),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then release key pulses.
    task automatic step();
        @(posedge clk);
        #1;
        shift_key = 1'b0;
        inc_key   = 1'b0;
        dec_key   = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, 32'(set_hour), 32'(h));
        chk({tag, ".min"},  32'(set_min),  32'(m));
        chk({tag, ".sec"},  32'(set_sec),  32'(s));
    endtask

    initial begin
        rst_n = 1'b0; set_time_en = 1'b0;
        shift_key = 1'b0; inc_key = 1'b0; dec_key = 1'b0;
        cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
        step(); step();
        chk_time("rst", 0, 0, 0);
        chk("rst.load", 32'(load_time), 0);
        chk("rst.sel",  32'(sel_field), 0);
        chk("rst.blink", 32'(blink), 0);

        // keys in idle are ignored, then entry captures 12:34:56
        rst_n = 1'b1;
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        inc_key = 1'b1; shift_key = 1'b1;
        step();
        chk_time("idle_keys", 0, 0, 0);
        chk("idle_keys.sel", 32'(sel_field), 0);
        set_time_en = 1'b1;
        step();
        chk_time("entry", 12, 34, 56);
        chk("entry.sel", 32'(sel_field), 1);
        chk("entry.blink", 32'(blink), 1);
        chk("entry.load", 32'(load_time), 0);

        // go to minute, decrement to 33, then reset mid-edit
        shift_key = 1'b1; step();
        chk("to_min.sel", 32'(sel_field), 2);
        dec_key = 1'b1; step();
        chk("min_dec", 32'(set_min), 33);
        rst_n = 1'b0; step();
        set_time_en = 1'b0;
        chk_time("mid_rst", 0, 0, 0);
        chk("mid_rst.sel", 32'(sel_field), 0);
        chk("mid_rst.blink", 32'(blink), 0);
        chk("mid_rst.load", 32'(load_time), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst.load", 32'(load_time), 0);
        end

        // hour and second wrap boundaries
        cur_hour = 5'd23; cur_min = 6'd45; cur_sec = 6'd0;
        set_time_en = 1'b1; step();
        chk("wrap.h23", 32'(set_hour), 23);
        inc_key = 1'b1; step();
        chk("hour_inc_wrap", 32'(set_hour), 0);
        dec_key = 1'b1; step();
        chk("hour_dec_wrap", 32'(set_hour), 23);
        shift_key = 1'b1; step();
        shift_key = 1'b1; step();
        chk("to_sec.sel", 32'(sel_field), 3);
        dec_key = 1'b1; step();
        chk("sec_dec_wrap", 32'(set_sec), 59);
        inc_key = 1'b1; step();
        chk("sec_inc_wrap", 32'(set_sec), 0);
        inc_key = 1'b1; dec_key = 1'b1; step();
        chk("inc_dec_cancel", 32'(set_sec), 0);
        chk_time("wrap_other", 23, 45, 0);
        set_time_en = 1'b0; step();
        chk("commit1.load", 32'(load_time), 1);
        chk_time("commit1", 23, 45, 0);
        step();
        chk("idle1.load", 32'(load_time), 0);
        chk("idle1.sel", 32'(sel_field), 0);

        // shift together with inc on minute
        cur_hour = 5'd7; cur_min = 6'd10; cur_sec = 6'd9;
        set_time_en = 1'b1; step();
        shift_key = 1'b1; step();
        chk("min10.sel", 32'(sel_field), 2);
        shift_key = 1'b1; inc_key = 1'b1; step();
        chk("shift_inc.min", 32'(set_min), 11);
        chk("shift_inc.sel", 32'(sel_field), 3);
        shift_key = 1'b1; step();
        chk("shift_wrap.sel", 32'(sel_field), 1);

        // edit to 07:08:09 and commit, re-raising enable in the commit cycle
        shift_key = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            dec_key = 1'b1; step();
        end
        chk_time("edited", 7, 8, 9);
        set_time_en = 1'b0; step();
        chk("commit2.load", 32'(load_time), 1);
        chk_time("commit2", 7, 8, 9);
        chk("commit2.sel", 32'(sel_field), 0);
        chk("commit2.blink", 32'(blink), 0);
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        set_time_en = 1'b1; step();
        chk("idle2.load", 32'(load_time), 0);
        chk("idle2.sel", 32'(sel_field), 0);
        chk_time("idle2_hold", 7, 8, 9);
        step();
        chk("reentry.sel", 32'(sel_field), 1);
        chk("reentry.load", 32'(load_time), 0);
        chk_time("reentry", 1, 2, 3);

        // blink period of 4 cycles from entry
        chk("blink.k0", 32'(blink), 1);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("blink.k%0d", k), 32'(blink), 32'(((k / 4) % 2) == 0));
        end
        // k=9 shows blink 1 (second visible half); move into a dark half first
        for (int k = 10; k <= 13; k++) begin
            step();
            chk($sformatf("blink.k%0d", k), 32'(blink), 32'(((k / 4) % 2) == 0));
        end
        // inc mid dark half restarts the period visible
        inc_key = 1'b1; step();
        chk("blink.inc", 32'(blink), 1);
        chk("blink.inc.hour", 32'(set_hour), 2);
        for (int j = 1; j <= 7; j++) begin
            step();
            chk($sformatf("blink.r%0d", j), 32'(blink), 32'(j < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
